// File: rtl/c64_io_pkg.sv
// Shared constants and types for the C64 ioctl download/upload paths.
// Both the PRG loader and the PRG uploader import this package.
package c64_io_pkg;

    localparam logic [3:0]  IEC_SLOT_CES = 4'b1011;
    localparam int unsigned PRG_HDR_LEN  = 2;

    localparam logic [7:0] IOCTL_IDX_ROM    = 8'd0;
    localparam logic [7:0] IOCTL_IDX_PRG    = 8'd2;
    localparam logic [7:0] IOCTL_IDX_CRT    = 8'd3;
    localparam logic [7:0] IOCTL_IDX_UPLOAD = 8'd4;

    typedef enum logic [2:0] {
        IDLE,
        PREFETCH,
        FETCH,
        READY,
        DONE
    } upload_state_t;

    // C64 address space is 64K; offsets wrap FFFF -> 0000.
    function automatic logic [15:0] c64_addr(input logic [15:0] base,
                                             input logic [15:0] offset);
        return base + offset;
    endfunction

endpackage

// File: rtl/sdram_slot_reader.sv
// Issues a single SDRAM read inside the spare IEC slot and strobes the data
// out when the slot ends. A request that has begun is always held to slot end.
module sdram_slot_reader #(
    parameter logic [24:0] RAM_BASE = 25'h0000000
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic        slot,
    input  logic        req,
    input  logic [15:0] addr,
    input  logic [7:0]  ram_din,
    output logic        ram_ce,
    output logic [24:0] ram_addr,
    output logic        launch,
    output logic        cap_valid,
    output logic [7:0]  cap_data
);

    logic        slot_d_reg;
    logic        active_reg;
    logic [24:0] addr_reg;
    logic [7:0]  data_reg;

    // Launch on the first cycle of a slot so ram_ce covers the whole slot.
    assign launch    = req && slot && !slot_d_reg && !active_reg;
    assign ram_ce    = slot && (active_reg || launch);
    assign ram_addr  = launch ? (RAM_BASE + {9'b0, addr}) : addr_reg;
    assign cap_valid = active_reg && !slot;
    assign cap_data  = data_reg;

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            slot_d_reg <= 1'b0;
            active_reg <= 1'b0;
            addr_reg   <= 25'd0;
            data_reg   <= 8'd0;
        end else begin
            slot_d_reg <= slot;
            if (launch) begin
                active_reg <= 1'b1;
                addr_reg   <= RAM_BASE + {9'b0, addr};
            end else if (cap_valid) begin
                active_reg <= 1'b0;
            end
            // The last sample taken while ram_ce is high is the valid one.
            if (ram_ce) begin
                data_reg <= ram_din;
            end
        end
    end

endmodule

// File: rtl/prg_upload.sv
// Streams a C64 RAM region to the HPS as a .PRG file: 2-byte load address
// header, then the RAM bytes, fetched one at a time in the spare IEC slot.
module prg_upload
    import c64_io_pkg::*;
#(
    parameter logic [24:0] RAM_BASE     = 25'h0000000,
    parameter logic [7:0]  UPLOAD_INDEX = IOCTL_IDX_UPLOAD
) (
    input  logic        clk32,
    input  logic        reset,
    input  logic [15:0] start_addr,
    input  logic [15:0] end_addr,
    input  logic        ioctl_upload,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_rd,
    input  logic [24:0] ioctl_addr,
    output logic [7:0]  ioctl_din,
    output logic        ioctl_wait,
    input  logic        slot,
    output logic        ram_ce,
    output logic [24:0] ram_addr,
    input  logic [7:0]  ram_din,
    output logic        busy
);

    upload_state_t state_reg, state_next;
    logic [15:0] start_reg, start_next;
    logic [15:0] len_reg, len_next;
    logic [15:0] offset_reg, offset_next;
    logic [7:0]  buf_reg, buf_next;
    logic        buf_full_reg, buf_full_next;
    logic        past_end_reg, past_end_next;
    logic        pending_reg, pending_next;
    logic [7:0]  din_reg, din_next;
    logic        wait_reg, wait_next;
    logic        sess_d_reg;

    logic        sess;
    logic        hdr_rd;
    logic        data_rd;
    logic        past_end_eff;
    logic        req;
    logic        launch;
    logic        cap_valid;
    logic [7:0]  cap_data;
    logic [15:0] fetch_addr;

    assign sess       = ioctl_upload && (ioctl_index == UPLOAD_INDEX);
    assign hdr_rd     = ioctl_rd && (ioctl_addr < 25'(PRG_HDR_LEN));
    assign data_rd    = ioctl_rd && !hdr_rd;
    assign fetch_addr = c64_addr(start_reg, offset_reg);
    // A zero-length file is past-end before its PREFETCH cycle is over.
    assign past_end_eff = past_end_reg || (state_reg == PREFETCH && len_reg == 16'd0);

    assign ioctl_din  = din_reg;
    assign ioctl_wait = wait_reg;
    assign busy       = (state_reg != IDLE);

    sdram_slot_reader #(
        .RAM_BASE (RAM_BASE)
    ) u_reader (
        .clk32     (clk32),
        .reset     (reset),
        .slot      (slot),
        .req       (req),
        .addr      (fetch_addr),
        .ram_din   (ram_din),
        .ram_ce    (ram_ce),
        .ram_addr  (ram_addr),
        .launch    (launch),
        .cap_valid (cap_valid),
        .cap_data  (cap_data)
    );

    always_ff @(posedge clk32 or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            start_reg    <= 16'd0;
            len_reg      <= 16'd0;
            offset_reg   <= 16'd0;
            buf_reg      <= 8'd0;
            buf_full_reg <= 1'b0;
            past_end_reg <= 1'b0;
            pending_reg  <= 1'b0;
            din_reg      <= 8'd0;
            wait_reg     <= 1'b0;
            sess_d_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            start_reg    <= start_next;
            len_reg      <= len_next;
            offset_reg   <= offset_next;
            buf_reg      <= buf_next;
            buf_full_reg <= buf_full_next;
            past_end_reg <= past_end_next;
            pending_reg  <= pending_next;
            din_reg      <= din_next;
            wait_reg     <= wait_next;
            sess_d_reg   <= sess;
        end
    end

    always_comb begin
        state_next    = state_reg;
        start_next    = start_reg;
        len_next      = len_reg;
        offset_next   = offset_reg;
        buf_next      = buf_reg;
        buf_full_next = buf_full_reg;
        past_end_next = past_end_reg;
        pending_next  = pending_reg;
        din_next      = din_reg;
        wait_next     = wait_reg;
        req           = 1'b0;

        case (state_reg)
            IDLE: begin
                wait_next    = 1'b0;
                pending_next = 1'b0;
                if (sess && !sess_d_reg) begin
                    start_next    = start_addr;
                    len_next      = end_addr - start_addr;
                    offset_next   = 16'd0;
                    buf_full_next = 1'b0;
                    past_end_next = 1'b0;
                    state_next    = PREFETCH;
                end
            end

            PREFETCH, FETCH, READY: begin
                if (hdr_rd) begin
                    din_next = ioctl_addr[0] ? start_reg[15:8] : start_reg[7:0];
                end

                if (state_reg == PREFETCH) begin
                    if (len_reg == 16'd0) begin
                        past_end_next = 1'b1;
                        state_next    = READY;
                    end else begin
                        req = 1'b1;
                        if (launch) begin
                            state_next = FETCH;
                        end
                    end
                end

                if (state_reg == FETCH && cap_valid) begin
                    offset_next = offset_reg + 16'd1;
                    if (pending_reg || data_rd) begin
                        // Waiting reader gets the byte straight off the slot.
                        din_next     = cap_data;
                        wait_next    = 1'b0;
                        pending_next = 1'b0;
                        if ((offset_reg + 16'd1) < len_reg) begin
                            state_next = PREFETCH;
                        end else begin
                            past_end_next = 1'b1;
                            state_next    = READY;
                        end
                    end else begin
                        buf_next      = cap_data;
                        buf_full_next = 1'b1;
                        state_next    = READY;
                    end
                end else if (data_rd) begin
                    if (buf_full_reg) begin
                        din_next      = buf_reg;
                        buf_full_next = 1'b0;
                        if (offset_reg < len_reg) begin
                            state_next = PREFETCH;
                        end else begin
                            past_end_next = 1'b1;
                        end
                    end else if (past_end_eff) begin
                        din_next = 8'h00;
                    end else begin
                        pending_next = 1'b1;
                        wait_next    = 1'b1;
                    end
                end

                // Session end wins; any slot already in flight is finished by the reader.
                if (!sess) begin
                    state_next   = DONE;
                    wait_next    = 1'b0;
                    pending_next = 1'b0;
                end
            end

            DONE: begin
                wait_next    = 1'b0;
                pending_next = 1'b0;
                state_next   = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
